// File: rtl/pwm_deadtime_gen.sv
// pwm_deadtime_gen: complementary high/low gate drive with a programmable dead time per transition.
// Optional latched fault input, clear pulse and FAULT state when PWM_DT_FAULT_EN is defined.
module pwm_deadtime_gen #(
   parameter int unsigned DT_WIDTH  = 8,
   parameter int unsigned INIT_SIDE = 0
) (
   input  logic                s00_axi_aclk,
   input  logic                s00_axi_aresetn,
   input  logic                pwm_in,
   input  logic                enable,
   input  logic [DT_WIDTH-1:0] dead_time,
`ifdef PWM_DT_FAULT_EN
   input  logic                fault,
   input  logic                fault_clr,
   output logic                fault_latched,
`endif
   output logic                pwm_hi,
   output logic                pwm_lo,
   output logic                dt_active
);

   localparam logic [DT_WIDTH-1:0] CNT_ONE = DT_WIDTH'(1);

   typedef enum logic [2:0] {
      S_OFF,
      S_DT_RISE,
      S_DT_FALL,
      S_LO_ON,
      S_HI_ON
`ifdef PWM_DT_FAULT_EN
      , S_FAULT
`endif
   } state_t;

   typedef enum logic [1:0] {
      SIDE_NONE,
      SIDE_LO,
      SIDE_HI
   } side_t;

   state_t              state, state_nxt;
   side_t               prev_side, prev_nxt;
   logic [DT_WIDTH-1:0] cnt, cnt_nxt, dt_load;
   logic                pwm_q;
`ifdef PWM_DT_FAULT_EN
   logic                fault_q;
`endif

   if (INIT_SIDE != 0) begin : g_init_side_check
      $error("INIT_SIDE is reserved and must be 0");
   end

   assign dt_load = (dead_time == '0) ? CNT_ONE : dead_time;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      prev_nxt  = prev_side;
      case (state)
         S_OFF: begin
            prev_nxt = SIDE_NONE;
            if (enable) begin
               state_nxt = pwm_q ? S_DT_RISE : S_DT_FALL;
               cnt_nxt   = dt_load;
            end
         end
         S_DT_RISE: begin
            // Pulse shorter than the dead time: go back to the side that only just released
            if (!pwm_q) begin
               if (prev_side == SIDE_LO) begin
                  state_nxt = S_LO_ON;
               end else begin
                  state_nxt = S_DT_FALL;
                  cnt_nxt   = dt_load;
               end
            end else if (cnt == CNT_ONE) begin
               state_nxt = S_HI_ON;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_DT_FALL: begin
            if (pwm_q) begin
               if (prev_side == SIDE_HI) begin
                  state_nxt = S_HI_ON;
               end else begin
                  state_nxt = S_DT_RISE;
                  cnt_nxt   = dt_load;
               end
            end else if (cnt == CNT_ONE) begin
               state_nxt = S_LO_ON;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         S_LO_ON: begin
            prev_nxt = SIDE_LO;
            if (pwm_q) begin
               state_nxt = S_DT_RISE;
               cnt_nxt   = dt_load;
            end
         end
         S_HI_ON: begin
            prev_nxt = SIDE_HI;
            if (!pwm_q) begin
               state_nxt = S_DT_FALL;
               cnt_nxt   = dt_load;
            end
         end
`ifdef PWM_DT_FAULT_EN
         S_FAULT: begin
            if (fault_clr && !fault_q) state_nxt = S_OFF;
         end
`endif
         default: state_nxt = S_OFF;
      endcase

`ifdef PWM_DT_FAULT_EN
      if (!enable && (state != S_FAULT)) state_nxt = S_OFF;
      if (fault_q) state_nxt = S_FAULT;
`else
      if (!enable) state_nxt = S_OFF;
`endif
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state     <= S_OFF;
         cnt       <= '0;
         prev_side <= SIDE_NONE;
         pwm_q     <= 1'b0;
         pwm_hi    <= 1'b0;
         pwm_lo    <= 1'b0;
         dt_active <= 1'b0;
`ifdef PWM_DT_FAULT_EN
         fault_q       <= 1'b0;
         fault_latched <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         prev_side <= prev_nxt;
         pwm_q     <= pwm_in;
         pwm_hi    <= (state_nxt == S_HI_ON);
         pwm_lo    <= (state_nxt == S_LO_ON);
         dt_active <= (state_nxt == S_DT_RISE) || (state_nxt == S_DT_FALL);
`ifdef PWM_DT_FAULT_EN
         fault_q       <= fault;
         fault_latched <= (state_nxt == S_FAULT);
`endif
      end
   end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// tb_pwm_deadtime_gen: directed scenarios plus randomized stimulus against a cycle-level model
// of the dead-time rules. Define PWM_DT_FAULT_EN to include the fault scenario.
module tb_pwm_deadtime_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       pwm_in = 1'b0;
   logic       enable = 1'b0;
   logic [7:0] dead_time = 8'd4;
   logic       pwm_hi, pwm_lo, dt_active;
`ifdef PWM_DT_FAULT_EN
   logic       fault = 1'b0;
   logic       fault_clr = 1'b0;
   logic       fault_latched;
`endif

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   always #5 clk = ~clk;

   pwm_deadtime_gen #(.DT_WIDTH(8), .INIT_SIDE(0)) dut (
      .s00_axi_aclk   (clk),
      .s00_axi_aresetn(rst_n),
      .pwm_in         (pwm_in),
      .enable         (enable),
      .dead_time      (dead_time),
`ifdef PWM_DT_FAULT_EN
      .fault          (fault),
      .fault_clr      (fault_clr),
      .fault_latched  (fault_latched),
`endif
      .pwm_hi         (pwm_hi),
      .pwm_lo         (pwm_lo),
      .dt_active      (dt_active)
   );

   // Model: side conducting (0 none, 1 lo, 2 hi), remaining dead cycles, side being approached,
   // side that conducted before this dead time, bridge running, fault latched.
   int m_side, m_dead, m_dir, m_last;
   bit m_on, m_flt, m_pq, m_fq;
   logic m_hi, m_lo, m_dt;
   assign m_hi = (m_side == 2);
   assign m_lo = (m_side == 1);
   assign m_dt = (m_dead > 0);

   always @(posedge clk or negedge rst_n) begin : model
      int side, dead, dir, last, want, load;
      bit on, flt;
      if (!rst_n) begin
         m_side <= 0; m_dead <= 0; m_dir <= 0; m_last <= 0;
         m_on <= 1'b0; m_flt <= 1'b0; m_pq <= 1'b0; m_fq <= 1'b0;
      end else begin
         side = m_side; dead = m_dead; dir = m_dir; last = m_last; on = m_on; flt = m_flt;
         want = m_pq ? 2 : 1;
         load = (dead_time == 8'd0) ? 1 : int'(dead_time);
`ifdef PWM_DT_FAULT_EN
         if (m_fq) begin
            flt = 1'b1; on = 1'b0; side = 0; dead = 0;
         end else if (flt) begin
            if (fault_clr) flt = 1'b0;
         end else
`endif
         if (!enable) begin
            on = 1'b0; side = 0; dead = 0;
         end else if (!on) begin
            on = 1'b1; last = 0; side = 0; dead = load; dir = want;
         end else if (dead > 0) begin
            if (want != dir) begin
               if (last == want) begin side = want; dead = 0; end
               else begin dead = load; dir = want; end
            end else if (dead == 1) begin
               side = want; dead = 0;
            end else begin
               dead = dead - 1;
            end
         end else if (want != side) begin
            last = side; side = 0; dead = load; dir = want;
         end
         m_side <= side; m_dead <= dead; m_dir <= dir; m_last <= last;
         m_on <= on; m_flt <= flt; m_pq <= pwm_in;
`ifdef PWM_DT_FAULT_EN
         m_fq <= fault;
`endif
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         n_checks++;
         if ((pwm_hi & pwm_lo) !== 1'b0) begin
            n_fail++;
            $display("FAIL overlap at %0t: hi=%b lo=%b, required not both 1", $time, pwm_hi, pwm_lo);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({pwm_hi, pwm_lo, dt_active} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: hi,lo,dt=%b%b%b required 000", pwm_hi, pwm_lo, dt_active);
      end
`ifdef PWM_DT_FAULT_EN
      n_checks++;
      if (fault_latched !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_fault_latched: got %b required 0", fault_latched);
      end
`endif
   endtask

   task automatic test_startup();
      int first_lo = -1, dt_cnt = 0, hi_cnt = 0;
      enable = 1'b1; dead_time = 8'd4; pwm_in = 1'b0; rst_n = 1'b1; chk_on = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n_checks++;
         if ({pwm_hi, pwm_lo, dt_active} !== {m_hi, m_lo, m_dt}) begin
            n_fail++;
            $display("FAIL startup_model cyc %0d: hi,lo,dt=%b%b%b required %b%b%b", k, pwm_hi, pwm_lo, dt_active, m_hi, m_lo, m_dt);
         end
         if (dt_active === 1'b1) dt_cnt++;
         if (pwm_hi === 1'b1) hi_cnt++;
         if (pwm_lo === 1'b1 && first_lo < 0) first_lo = k;
      end
      n_checks++;
      if (first_lo != 5) begin n_fail++; $display("FAIL startup_lo_cycle: got %0d required 5", first_lo); end
      n_checks++;
      if (dt_cnt != 4) begin n_fail++; $display("FAIL startup_dt_cycles: got %0d required 4", dt_cnt); end
      n_checks++;
      if (hi_cnt != 0) begin n_fail++; $display("FAIL startup_hi_quiet: got %0d hi cycles required 0", hi_cnt); end
   endtask

   task automatic test_edges();
      int lo_off, hi_on, hi_off, lo_on, dt_r, dt_f;
      lo_off = -1; hi_on = -1; hi_off = -1; lo_on = -1; dt_r = 0; dt_f = 0;
      pwm_in = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         n_checks++;
         if ({pwm_hi, pwm_lo, dt_active} !== {m_hi, m_lo, m_dt}) begin
            n_fail++;
            $display("FAIL edges_rise_model cyc %0d: hi,lo,dt=%b%b%b required %b%b%b", k, pwm_hi, pwm_lo, dt_active, m_hi, m_lo, m_dt);
         end
         if (pwm_lo === 1'b0 && lo_off < 0) lo_off = k;
         if (pwm_hi === 1'b1 && hi_on < 0) hi_on = k;
         if (dt_active === 1'b1) dt_r++;
      end
      pwm_in = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         n_checks++;
         if ({pwm_hi, pwm_lo, dt_active} !== {m_hi, m_lo, m_dt}) begin
            n_fail++;
            $display("FAIL edges_fall_model cyc %0d: hi,lo,dt=%b%b%b required %b%b%b", k, pwm_hi, pwm_lo, dt_active, m_hi, m_lo, m_dt);
         end
         if (pwm_hi === 1'b0 && hi_off < 0) hi_off = k;
         if (pwm_lo === 1'b1 && lo_on < 0) lo_on = k;
         if (dt_active === 1'b1) dt_f++;
      end
      n_checks++;
      if (lo_off != 2) begin n_fail++; $display("FAIL edges_lo_fall: got cyc %0d required 2", lo_off); end
      n_checks++;
      if (hi_on != 6) begin n_fail++; $display("FAIL edges_hi_rise: got cyc %0d required 6", hi_on); end
      n_checks++;
      if (hi_off != 2) begin n_fail++; $display("FAIL edges_hi_fall: got cyc %0d required 2", hi_off); end
      n_checks++;
      if (lo_on != 6) begin n_fail++; $display("FAIL edges_lo_rise: got cyc %0d required 6", lo_on); end
      n_checks++;
      if (dt_r != 4 || dt_f != 4) begin n_fail++; $display("FAIL edges_dt_len: got %0d/%0d required 4/4", dt_r, dt_f); end
   endtask

   task automatic test_dt_bounds();
      int dts[2] = '{0, 255};
      for (int i = 0; i < 2; i++) begin
         int first_hi = -1, dt_cnt = 0, d_eff;
         d_eff = (dts[i] == 0) ? 1 : dts[i];
         dead_time = 8'(dts[i]);
         pwm_in = 1'b1;
         for (int k = 1; k <= 300 && first_hi < 0; k++) begin
            @(negedge clk);
            n_checks++;
            if ({pwm_hi, pwm_lo, dt_active} !== {m_hi, m_lo, m_dt}) begin
               n_fail++;
               $display("FAIL dtb_model dt=%0d cyc %0d: hi,lo,dt=%b%b%b required %b%b%b", dts[i], k, pwm_hi, pwm_lo, dt_active, m_hi, m_lo, m_dt);
            end
            if (dt_active === 1'b1) dt_cnt++;
            if (pwm_hi === 1'b1) first_hi = k;
         end
         n_checks++;
         if (dt_cnt != d_eff) begin n_fail++; $display("FAIL dtb_dead_cycles dt=%0d: got %0d required %0d", dts[i], dt_cnt, d_eff); end
         n_checks++;
         if (first_hi != d_eff + 2) begin n_fail++; $display("FAIL dtb_hi_latency dt=%0d: got %0d required %0d", dts[i], first_hi, d_eff + 2); end
         pwm_in = 1'b0;
         repeat (d_eff + 4) @(negedge clk);
         n_checks++;
         if ({pwm_hi, pwm_lo} !== 2'b01) begin n_fail++; $display("FAIL dtb_back_to_lo dt=%0d: hi,lo=%b%b required 01", dts[i], pwm_hi, pwm_lo); end
      end
   endtask

   task automatic test_abort();
      int hi_cnt = 0, dt_cnt = 0, lo_off = 0;
      dead_time = 8'd8;
      pwm_in = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (k == 3) pwm_in = 1'b0;
         n_checks++;
         if ({pwm_hi, pwm_lo, dt_active} !== {m_hi, m_lo, m_dt}) begin
            n_fail++;
            $display("FAIL abort_model cyc %0d: hi,lo,dt=%b%b%b required %b%b%b", k, pwm_hi, pwm_lo, dt_active, m_hi, m_lo, m_dt);
         end
         if (pwm_hi === 1'b1) hi_cnt++;
         if (dt_active === 1'b1) dt_cnt++;
         if (pwm_lo === 1'b0) lo_off++;
      end
      n_checks++;
      if (hi_cnt != 0) begin n_fail++; $display("FAIL abort_hi_quiet: got %0d hi cycles required 0", hi_cnt); end
      n_checks++;
      if (dt_cnt != 3 || lo_off != 3) begin n_fail++; $display("FAIL abort_gap: got dt %0d lo_off %0d required 3/3", dt_cnt, lo_off); end
   endtask

   task automatic test_enable_reset();
      int first_hi = -1, dt_cnt = 0;
      dead_time = 8'd4;
      pwm_in = 1'b1;
      repeat (8) @(negedge clk);
      n_checks++;
      if (pwm_hi !== 1'b1) begin n_fail++; $display("FAIL en_hi_reached: got %b required 1", pwm_hi); end
      enable = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({pwm_hi, pwm_lo, dt_active} !== 3'b000) begin n_fail++; $display("FAIL en_off: hi,lo,dt=%b%b%b required 000", pwm_hi, pwm_lo, dt_active); end
      enable = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (dt_active !== 1'b1) begin n_fail++; $display("FAIL rst_in_dt: dt=%b required 1", dt_active); end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({pwm_hi, pwm_lo, dt_active} !== 3'b000) begin n_fail++; $display("FAIL rst_async: hi,lo,dt=%b%b%b required 000", pwm_hi, pwm_lo, dt_active); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         n_checks++;
         if ({pwm_hi, pwm_lo, dt_active} !== {m_hi, m_lo, m_dt}) begin
            n_fail++;
            $display("FAIL rst_restart_model cyc %0d: hi,lo,dt=%b%b%b required %b%b%b", k, pwm_hi, pwm_lo, dt_active, m_hi, m_lo, m_dt);
         end
         if (dt_active === 1'b1 && first_hi < 0) dt_cnt++;
         if (pwm_hi === 1'b1 && first_hi < 0) first_hi = k;
      end
      n_checks++;
      if (first_hi < 5 || dt_cnt < 4) begin n_fail++; $display("FAIL rst_full_dead: got hi cyc %0d dt %0d required >=5 and >=4", first_hi, dt_cnt); end
   endtask

`ifdef PWM_DT_FAULT_EN
   task automatic test_fault();
      int first_hi = -1;
      fault = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({fault_latched, pwm_hi, pwm_lo, dt_active} !== 4'b1000) begin
         n_fail++; $display("FAIL fault_entry: flt,hi,lo,dt=%b%b%b%b required 1000", fault_latched, pwm_hi, pwm_lo, dt_active);
      end
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      @(negedge clk);
      n_checks++;
      if (fault_latched !== 1'b1) begin n_fail++; $display("FAIL fault_clr_ignored: got %b required 1", fault_latched); end
      fault = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++;
      if (fault_latched !== 1'b1) begin n_fail++; $display("FAIL fault_sticky: got %b required 1", fault_latched); end
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      n_checks++;
      if (fault_latched !== 1'b0) begin n_fail++; $display("FAIL fault_cleared: got %b required 0", fault_latched); end
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         n_checks++;
         if ({fault_latched, pwm_hi, pwm_lo, dt_active} !== {m_flt, m_hi, m_lo, m_dt}) begin
            n_fail++;
            $display("FAIL fault_restart_model cyc %0d: flt,hi,lo,dt=%b%b%b%b required %b%b%b%b", k, fault_latched, pwm_hi, pwm_lo, dt_active, m_flt, m_hi, m_lo, m_dt);
         end
         if (pwm_hi === 1'b1 && first_hi < 0) first_hi = k;
      end
      n_checks++;
      if (first_hi != 5) begin n_fail++; $display("FAIL fault_restart_hi: got cyc %0d required 5", first_hi); end
   endtask
`endif

   task automatic test_random();
      for (int k = 1; k <= 1500; k++) begin
         if ($urandom_range(5, 0) == 0) pwm_in = ~pwm_in;
         if ($urandom_range(39, 0) == 0) dead_time = 8'($urandom_range(10, 0));
         enable = ($urandom_range(149, 0) != 0);
`ifdef PWM_DT_FAULT_EN
         fault     = ($urandom_range(299, 0) == 0);
         fault_clr = ($urandom_range(9, 0) == 0);
`endif
         @(negedge clk);
         n_checks++;
         if ({pwm_hi, pwm_lo, dt_active} !== {m_hi, m_lo, m_dt}) begin
            n_fail++;
            $display("FAIL random_model cyc %0d: hi,lo,dt=%b%b%b required %b%b%b", k, pwm_hi, pwm_lo, dt_active, m_hi, m_lo, m_dt);
         end
`ifdef PWM_DT_FAULT_EN
         n_checks++;
         if (fault_latched !== m_flt) begin
            n_fail++;
            $display("FAIL random_fault cyc %0d: got %b required %b", k, fault_latched, m_flt);
         end
`endif
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      test_reset();
      test_startup();
      test_edges();
      test_dt_bounds();
      test_abort();
      test_enable_reset();
`ifdef PWM_DT_FAULT_EN
      test_fault();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached before end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
